// File: rtl/gmii_rx_frame_checker_pkg.sv
// Shared constants and state encoding for the GMII receive frame checker
// and the companion CRC32 byte-step logic.
package gmii_rx_frame_checker_pkg;

    localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
    localparam logic [7:0]  GMII_SFD      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_PREAMBLE = 2'b01,
        ST_DATA     = 2'b10,
        ST_DROP     = 2'b11
    } rx_state_t;

    // The residue constant is quoted MSB-first; the LSB-first register
    // holds its bit mirror (0xDEBB20E3) after a clean frame.
    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/gmii_rx_frame_checker_crc32_d8.sv
// crc32_d8: combinational next-state of the reflected Ethernet CRC32 for
// one input byte. Shared with the TX FCS generator.
module crc32_d8 (
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);
    import gmii_rx_frame_checker_pkg::*;

    always_comb begin : p_step
        logic [31:0] w_c;
        // NOTE: w_c is fully assigned before any use, so no latch is inferred.
        w_c = i_crc ^ {24'h0, i_data};
        for (int i = 0; i < 8; i++) begin
            w_c = w_c[0] ? ((w_c >> 1) ^ CRC32_POLY) : (w_c >> 1);
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/gmii_rx_frame_checker.sv
// GMII receive frame checker: strips preamble/SFD, withholds the FCS and
// flags CRC, RX_ER, runt and overlength errors. Define RX_STAT_COUNTERS_EN
// to build the good/bad frame statistics counters.
module gmii_rx_frame_checker #(
    parameter int MAX_FRAME_LEN = 1522,
    parameter int MIN_FRAME_LEN = 64
) (
    input  logic        GMII_CLK,
    input  logic        RESET_IN,
    input  logic [7:0]  GMII_RXD,
    input  logic        GMII_RX_DV,
    input  logic        GMII_RX_ER,
    output logic [7:0]  RX_DATA,
    output logic        RX_VALID,
    output logic        RX_SOF,
    output logic        RX_EOF,
    output logic        RX_GOOD,
    output logic        RX_BAD,
    output logic [31:0] STAT_GOOD_CNT,
    output logic [31:0] STAT_BAD_CNT
);
    import gmii_rx_frame_checker_pkg::*;

    localparam logic [10:0] L_MAX = 11'(MAX_FRAME_LEN);
    localparam logic [10:0] L_MIN = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] L_SAT = 11'h7FF;

    logic [7:0]  r_rxd;
    logic        r_dv;
    logic        r_er;
    rx_state_t   r_state;
    logic [31:0] r_crc;
    logic [10:0] r_cnt;
    logic        r_err;
    logic [31:0] r_dly;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_sof;
    logic        r_eof;
    logic        r_good;
    logic        r_bad;
    logic [31:0] w_crc_next;
    logic        w_frame_ok;

`ifdef RX_STAT_COUNTERS_EN
    logic [31:0] r_good_cnt;
    logic [31:0] r_bad_cnt;
`endif

    crc32_d8 u_crc (
        .i_crc  (r_crc),
        .i_data (r_rxd),
        .o_crc  (w_crc_next)
    );

    assign w_frame_ok = (bit_reverse32(r_crc) == CRC32_RESIDUE) && !r_err && (r_cnt >= L_MIN);

    // Input capture stage; together with the 4-byte FCS delay line it gives
    // the 5-cycle pass-through latency.
    always_ff @(posedge GMII_CLK or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_rxd <= 8'h00;
            r_dv  <= 1'b0;
            r_er  <= 1'b0;
        end else begin
            r_rxd <= GMII_RXD;
            r_dv  <= GMII_RX_DV;
            r_er  <= GMII_RX_ER;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge GMII_CLK or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_state <= ST_DROP;
            r_crc   <= CRC32_INIT;
            r_cnt   <= 11'd0;
            r_err   <= 1'b0;
            r_dly   <= 32'h0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_good  <= 1'b0;
            r_bad   <= 1'b0;
`ifdef RX_STAT_COUNTERS_EN
            r_good_cnt <= 32'd0;
            r_bad_cnt  <= 32'd0;
`endif
        end else begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_good  <= 1'b0;
            r_bad   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_PREAMBLE: begin
                    if (!r_dv) begin
                        r_state <= ST_IDLE;
                    end else if (r_rxd == GMII_SFD) begin
                        r_state <= ST_DATA;
                        r_crc   <= CRC32_INIT;
                        r_cnt   <= 11'd0;
                        r_err   <= 1'b0;
                    end else if (r_rxd == GMII_PREAMBLE) begin
                        r_state <= ST_PREAMBLE;
                    end else begin
                        r_state <= ST_DROP;
`ifdef RX_STAT_COUNTERS_EN
                        r_bad_cnt <= r_bad_cnt + 32'd1;
`endif
                    end
                end
                ST_DATA: begin
                    if (r_dv && (r_cnt == L_MAX)) begin
                        // Byte MAX+1: abort now; the EOF lands one cycle after the last data byte.
                        r_state <= ST_DROP;
                        r_cnt   <= r_cnt + 11'd1;
                        r_eof   <= 1'b1;
                        r_bad   <= 1'b1;
`ifdef RX_STAT_COUNTERS_EN
                        r_bad_cnt <= r_bad_cnt + 32'd1;
`endif
                    end else if (r_dv) begin
                        r_crc <= w_crc_next;
                        r_cnt <= (r_cnt == L_SAT) ? r_cnt : r_cnt + 11'd1;
                        r_err <= r_err | r_er;
                        r_dly <= {r_dly[23:0], r_rxd};
                        if (r_cnt >= 11'd4) begin
                            r_data  <= r_dly[31:24];
                            r_valid <= 1'b1;
                            r_sof   <= (r_cnt == 11'd4);
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        // Under 5 bytes no SOF went out, so the frame ends silently.
                        if (r_cnt >= 11'd5) begin
                            r_eof  <= 1'b1;
                            r_good <= w_frame_ok;
                            r_bad  <= !w_frame_ok;
`ifdef RX_STAT_COUNTERS_EN
                            if (w_frame_ok) r_good_cnt <= r_good_cnt + 32'd1;
                            else            r_bad_cnt  <= r_bad_cnt + 32'd1;
                        end else begin
                            r_bad_cnt <= r_bad_cnt + 32'd1;
`endif
                        end
                    end
                end
                ST_DROP: begin
                    if (!r_dv) r_state <= ST_IDLE;
                end
                default: r_state <= ST_DROP;
            endcase
        end
    end

    assign RX_DATA  = r_data;
    assign RX_VALID = r_valid;
    assign RX_SOF   = r_sof;
    assign RX_EOF   = r_eof;
    assign RX_GOOD  = r_good;
    assign RX_BAD   = r_bad;

`ifdef RX_STAT_COUNTERS_EN
    assign STAT_GOOD_CNT = r_good_cnt;
    assign STAT_BAD_CNT  = r_bad_cnt;
`else
    assign STAT_GOOD_CNT = 32'd0;
    assign STAT_BAD_CNT  = 32'd0;
`endif

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Bench for gmii_rx_frame_checker; define RX_STAT_COUNTERS_EN to cover the
// statistics counters as well.
module tb_gmii_rx_frame_checker;

    localparam int MAX_LEN = 1522;
    localparam int MIN_LEN = 64;
    localparam int LIMIT   = 12000;
    localparam int TAB_SZ  = 16384;

    typedef byte unsigned bq_t[$];
    typedef struct packed {
        logic       v;
        logic       s;
        logic       e;
        logic       g;
        logic       b;
        logic [7:0] d;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rxd = 8'h00;
    logic        dv  = 1'b0;
    logic        er  = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_good, rx_bad;
    logic [31:0] stat_good, stat_bad;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    obs_t exp_tab [0:TAB_SZ-1];
    int   exp_good = 0;
    int   exp_bad = 0;
    int   obs_valid = 0;
    int   obs_good = 0;
    int   obs_bad = 0;
    int   obs_sof_edge = -1;
    int   last_k0 = 0;

    gmii_rx_frame_checker #(
        .MAX_FRAME_LEN (MAX_LEN),
        .MIN_FRAME_LEN (MIN_LEN)
    ) dut (
        .GMII_CLK      (clk),
        .RESET_IN      (rst),
        .GMII_RXD      (rxd),
        .GMII_RX_DV    (dv),
        .GMII_RX_ER    (er),
        .RX_DATA       (rx_data),
        .RX_VALID      (rx_valid),
        .RX_SOF        (rx_sof),
        .RX_EOF        (rx_eof),
        .RX_GOOD       (rx_good),
        .RX_BAD        (rx_bad),
        .STAT_GOOD_CNT (stat_good),
        .STAT_BAD_CNT  (stat_bad)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Standard Ethernet FCS value (reflected CRC32, final inversion).
    function automatic logic [31:0] crc32(input bq_t q, input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t make_frame(input int npay, input int seed);
        bq_t f;
        logic [31:0] fcs;
        for (int i = 0; i < npay; i++) f.push_back(8'(i * 13 + seed));
        fcs = crc32(f, npay);
        f.push_back(fcs[7:0]);
        f.push_back(fcs[15:8]);
        f.push_back(fcs[23:16]);
        f.push_back(fcs[31:24]);
        return f;
    endfunction

    // Frame verdict from first principles: length window, no RX_ER, trailing
    // four bytes equal the FCS of everything before them.
    function automatic logic frame_ok(input bq_t f, input int er_idx);
        int n;
        logic [31:0] fcs;
        n = f.size();
        if (n < MIN_LEN || n > MAX_LEN) return 1'b0;
        if (er_idx >= 0 && er_idx < n) return 1'b0;
        fcs = {f[n-1], f[n-2], f[n-3], f[n-4]};
        return crc32(f, n - 4) == fcs;
    endfunction

    always @(negedge clk) begin : p_cmp
        obs_t a;
        obs_t r;
        a = {rx_valid, rx_sof, rx_eof, rx_good, rx_bad, rx_valid ? rx_data : 8'h00};
        r = exp_tab[cyc];
        check($sformatf("outputs_edge%0d", cyc), 64'(a), 64'(r));
        if (rx_valid) obs_valid++;
        if (rx_valid && rx_sof) obs_sof_edge = cyc;
        if (rx_eof && rx_good) obs_good++;
        if (rx_eof && rx_bad) obs_bad++;
    end

    always @(posedge clk) begin
        if (cyc > LIMIT) begin
            total++;
            bad++;
            $display("FAIL timeout actual=%0d required<=%0d cycles", cyc, LIMIT);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic e, output int k);
        @(posedge clk);
        #1;
        dv  = v;
        rxd = d;
        er  = e;
        k   = cyc + 1;
    endtask

    task automatic idle(input int n);
        int k;
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, k);
    endtask

    task automatic send_frame(input bq_t f, input int pre_len, input int er_idx,
                              input int rst_idx, input int gap);
        int   k;
        int   n;
        logic good;
        logic aborted;
        n       = f.size();
        good    = frame_ok(f, er_idx);
        aborted = 1'b0;
        for (int i = 0; i < pre_len; i++) drive(1'b1, 8'h55, 1'b0, k);
        drive(1'b1, 8'hD5, 1'b0, k);
        for (int i = 0; i < n; i++) begin
            if (i == rst_idx) begin
                @(posedge clk);
                #1;
                rst = 1'b1;
                for (int c = cyc; c < TAB_SZ; c++) exp_tab[c] = '0;
                exp_good = 0;
                exp_bad  = 0;
                aborted  = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
            end
            drive(1'b1, f[i], 1'b1 && (i == er_idx), k);
            if (i == 0) last_k0 = k;
            if (!aborted) begin
                if (i < n - 4 && i < MAX_LEN - 4)
                    exp_tab[k+5] = {1'b1, 1'(i == 0), 3'b000, f[i]};
                if (i == MAX_LEN) begin
                    exp_tab[k+1] = {3'b001, 1'b0, 1'b1, 8'h00};
                    exp_bad++;
                end
                if (i == n - 1 && n <= MAX_LEN) begin
                    if (n >= 5) begin
                        exp_tab[k+2] = {3'b001, good, !good, 8'h00};
                        if (good) exp_good++;
                        else      exp_bad++;
                    end else begin
                        exp_bad++;
                    end
                end
            end
        end
        idle(gap);
    endtask

    task automatic check_stats(input string tag);
`ifdef RX_STAT_COUNTERS_EN
        check({tag, "_good_cnt"}, 64'(stat_good), 64'(exp_good));
        check({tag, "_bad_cnt"},  64'(stat_bad),  64'(exp_bad));
`else
        check({tag, "_good_cnt"}, 64'(stat_good), 64'd0);
        check({tag, "_bad_cnt"},  64'(stat_bad),  64'd0);
`endif
    endtask

    initial begin : p_main
        bq_t f;
        bq_t g;
        bq_t s;
        int  k;
        int  g0;
        int  b0;
        logic [31:0] sg0;

        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("crc32_pin_123456789", 64'(crc32(s, 9)), 64'hCBF43926);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_stats("reset");
        idle(4);

        // Good 64-byte frame.
        f = make_frame(60, 1);
        obs_valid = 0;
        send_frame(f, 7, -1, -1, 12);
        check("f1_valid_bytes", 64'(obs_valid), 64'd60);
        check("f1_sof_latency", 64'(obs_sof_edge - last_k0), 64'd5);
        check("f1_good_pulses", 64'(obs_good), 64'd1);
        check_stats("f1");

        // Payload byte 10 corrupted.
        g = f;
        g[10] = g[10] ^ 8'hFF;
        obs_valid = 0;
        send_frame(g, 7, -1, -1, 12);
        check("f2_valid_bytes", 64'(obs_valid), 64'd60);
        check("f2_bad_pulses", 64'(obs_bad), 64'd1);
`ifdef RX_STAT_COUNTERS_EN
        check("f2_bad_cnt_literal", 64'(stat_bad), 64'd1);
`else
        check("f2_bad_cnt_literal", 64'(stat_bad), 64'd0);
`endif

        // RX_ER on byte 20, then 40-byte and 63-byte runts.
        send_frame(f, 7, 20, -1, 12);
        send_frame(make_frame(36, 3), 7, -1, -1, 12);
        send_frame(make_frame(59, 4), 7, -1, -1, 12);
        check("runts_bad_pulses", 64'(obs_bad), 64'd4);
        check_stats("runts");

        // Overlength, then exactly maximum length.
        g.delete();
        for (int i = 0; i < 1600; i++) g.push_back(8'(i * 5 + 2));
        obs_valid = 0;
        send_frame(g, 7, -1, -1, 12);
        check("ovl_valid_bytes", 64'(obs_valid), 64'd1518);
        obs_valid = 0;
        g0 = obs_good;
        send_frame(make_frame(1518, 5), 7, -1, -1, 12);
        check("max_valid_bytes", 64'(obs_valid), 64'd1518);
        check("max_good_pulse", 64'(obs_good - g0), 64'd1);
        check_stats("long");

        // Back-to-back with one idle cycle; second frame has no preamble.
        g0  = obs_good;
        sg0 = stat_good;
        send_frame(make_frame(60, 6), 7, -1, -1, 1);
        send_frame(make_frame(100, 7), 0, -1, -1, 12);
        check("b2b_good_pulses", 64'(obs_good - g0), 64'd2);
`ifdef RX_STAT_COUNTERS_EN
        check("b2b_good_cnt_delta", 64'(stat_good - sg0), 64'd2);
`else
        check("b2b_good_cnt_delta", 64'(stat_good - sg0), 64'd0);
`endif

        // Tiny frame, preamble abort, illegal first byte.
        g0 = obs_good;
        b0 = obs_bad;
        g  = '{8'h11, 8'h22, 8'h33};
        send_frame(g, 7, -1, -1, 8);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h55, 1'b0, k);
        idle(5);
        drive(1'b1, 8'h12, 1'b0, k);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h55, 1'b0, k);
        idle(5);
        exp_bad++;
        check("quiet_no_eof", 64'((obs_good - g0) + (obs_bad - b0)), 64'd0);
        check_stats("quiet");

        // Reset for 3 cycles mid-payload, then a fresh good frame.
        send_frame(make_frame(60, 8), 7, -1, 30, 6);
        check_stats("post_reset");
        g0 = obs_good;
        obs_valid = 0;
        send_frame(make_frame(60, 9), 7, -1, -1, 12);
        check("after_reset_valid", 64'(obs_valid), 64'd60);
        check("after_reset_good", 64'(obs_good - g0), 64'd1);
        check_stats("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
